// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader: receives a framed program (count, words, XOR checksum),
// writes it into instruction memory and releases the MIPS core on a checksum match.
module imem_boot_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_CNT_HI,
        S_CNT_LO,
        S_DATA,
        S_CSUM,
        S_RUN,
        S_ERR
    } state_t;

    localparam logic [16:0]     MAX_N = 17'd1 << ADDR_W;
    localparam logic [ADDR_W:0] ONE_W = 1;

    state_t              state_reg, state_next;
    logic [7:0]          cnt_hi_reg, cnt_hi_next;
    logic [ADDR_W:0]     n_reg, n_next;
    logic [ADDR_W:0]     widx_reg, widx_next;
    logic [1:0]          bcnt_reg, bcnt_next;
    logic [23:0]         wbuf_reg, wbuf_next;
    logic [7:0]          xor_reg, xor_next;
    logic                we_reg, we_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [31:0]         wdata_reg, wdata_next;
    logic                run_reg, err_reg;

    logic                accept;
    logic [16:0]         n_full;
    logic [ADDR_W:0]     widx_inc;

    assign rx_ready = (state_reg == S_CNT_HI) || (state_reg == S_CNT_LO) ||
                      (state_reg == S_DATA)   || (state_reg == S_CSUM);
    assign busy     = rx_ready;
    assign accept   = rx_valid && rx_ready;
    assign n_full   = {1'b0, cnt_hi_reg, rx_data};
    assign widx_inc = widx_reg + ONE_W;

    always_comb begin
        state_next  = state_reg;
        cnt_hi_next = cnt_hi_reg;
        n_next      = n_reg;
        widx_next   = widx_reg;
        bcnt_next   = bcnt_reg;
        wbuf_next   = wbuf_reg;
        xor_next    = xor_reg;
        we_next     = 1'b0;
        addr_next   = addr_reg;
        wdata_next  = wdata_reg;
        case (state_reg)
            S_CNT_HI: begin
                if (accept) begin
                    cnt_hi_next = rx_data;
                    state_next  = S_CNT_LO;
                end
            end
            S_CNT_LO: begin
                if (accept) begin
                    if (n_full > MAX_N) begin
                        state_next = S_ERR;
                    end else begin
                        n_next     = n_full[ADDR_W:0];
                        state_next = (n_full == 17'd0) ? S_CSUM : S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    xor_next  = xor_reg ^ rx_data;
                    bcnt_next = bcnt_reg + 2'd1;
                    wbuf_next = {wbuf_reg[15:0], rx_data};
                    // Fourth byte completes the word: write it straight out of the shifter.
                    if (bcnt_reg == 2'd3) begin
                        we_next    = 1'b1;
                        addr_next  = widx_reg[ADDR_W-1:0];
                        wdata_next = {wbuf_reg, rx_data};
                        widx_next  = widx_inc;
                        if (widx_inc == n_reg)
                            state_next = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (accept)
                    state_next = (rx_data == xor_reg) ? S_RUN : S_ERR;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_CNT_HI;
            cnt_hi_reg <= '0;
            n_reg      <= '0;
            widx_reg   <= '0;
            bcnt_reg   <= '0;
            wbuf_reg   <= '0;
            xor_reg    <= '0;
            we_reg     <= 1'b0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            run_reg    <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_hi_reg <= cnt_hi_next;
            n_reg      <= n_next;
            widx_reg   <= widx_next;
            bcnt_reg   <= bcnt_next;
            wbuf_reg   <= wbuf_next;
            xor_reg    <= xor_next;
            we_reg     <= we_next;
            addr_reg   <= addr_next;
            wdata_reg  <= wdata_next;
            // Status flags are registered from the next state so cpu_rst_n cannot glitch.
            run_reg    <= (state_next == S_RUN);
            err_reg    <= (state_next == S_ERR);
        end
    end

    assign imem_we    = we_reg;
    assign imem_addr  = addr_reg;
    assign imem_wdata = wdata_reg;
    assign cpu_rst_n  = run_reg;
    assign done       = run_reg;
    assign err        = err_reg;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: stimulus pushes expected writes, a monitor
// pops and compares each imem_we pulse; status outputs are checked at fixed points.
module tb_imem_boot_loader;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_rst_n;
    logic              busy;
    logic              done;
    logic              err;

    int checks = 0;
    int errors = 0;
    logic [ADDR_W+31:0] exp_q[$];

    imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst_n  (cpu_rst_n),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Write monitor: one line per observed write.
    initial begin
        logic [ADDR_W+31:0] e;
        forever begin
            @(negedge clk);
            if (imem_we === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write actual=%h/%h required=none", imem_addr, imem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    if ({imem_addr, imem_wdata} !== e) begin
                        errors++;
                        $display("FAIL write actual=%h/%h required=%h/%h",
                                 imem_addr, imem_wdata, e[ADDR_W+31:32], e[31:0]);
                    end else begin
                        $display("write addr=%h data=%h ok", imem_addr, imem_wdata);
                    end
                end
            end
        end
    end

    task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic send(input logic [7:0] b, input logic exp_rdy, input int gap);
        rx_valid = 1'b1;
        rx_data  = b;
        chk("rx_ready", {31'd0, rx_ready}, {31'd0, exp_rdy});
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        for (int i = 0; i < gap; i++) begin
            @(posedge clk); #1;
            rx_data = 8'($urandom);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst_imem_we", {31'd0, imem_we}, 0);
        chk("rst_imem_addr", {24'd0, imem_addr}, 0);
        chk("rst_imem_wdata", imem_wdata, 0);
        chk("rst_cpu_rst_n", {31'd0, cpu_rst_n}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_err", {31'd0, err}, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_busy", {31'd0, busy}, 1);
    endtask

    task automatic status(input string name, input logic d, input logic e, input logic rdy);
        chk({name, "_done"}, {31'd0, done}, {31'd0, d});
        chk({name, "_cpu_rst_n"}, {31'd0, cpu_rst_n}, {31'd0, d});
        chk({name, "_err"}, {31'd0, err}, {31'd0, e});
        chk({name, "_rx_ready"}, {31'd0, rx_ready}, {31'd0, rdy});
        chk({name, "_busy"}, {31'd0, busy}, {31'd0, rdy});
    endtask

    task automatic nominal(input logic [7:0] csum, input int gap);
        logic [7:0] s [10];
        s = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
        push_wr(8'd0, 32'h20080005);
        push_wr(8'd1, 32'h01095020);
        foreach (s[i]) send(s[i], 1'b1, gap);
        chk("pre_csum_cpu_rst_n", {31'd0, cpu_rst_n}, 0);
        send(csum, 1'b1, 0);
    endtask

    initial begin
        logic [7:0] b, x;
        logic [31:0] w;

        // Reset state
        do_reset();
        status("reset", 1'b0, 1'b0, 1'b1);

        // Nominal load, full rate
        nominal(8'h55, 0);
        status("nominal", 1'b1, 1'b0, 1'b0);
        chk("nominal_pending", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        status("nominal_hold", 1'b1, 1'b0, 1'b0);

        // Bad checksum; trailing bytes must be ignored
        do_reset();
        nominal(8'h54, 0);
        status("badcsum", 1'b0, 1'b1, 1'b0);
        chk("badcsum_pending", exp_q.size(), 0);
        for (int i = 0; i < 4; i++) send(8'hA5, 1'b0, 0);
        status("badcsum_after", 1'b0, 1'b1, 1'b0);

        // Empty program
        do_reset();
        send(8'h00, 1'b1, 0);
        send(8'h00, 1'b1, 0);
        chk("empty_pre_done", {31'd0, done}, 0);
        send(8'h00, 1'b1, 0);
        status("empty", 1'b1, 1'b0, 1'b0);

        // Oversize count N=257
        do_reset();
        send(8'h01, 1'b1, 0);
        chk("oversize_pre_err", {31'd0, err}, 0);
        send(8'h01, 1'b1, 0);
        status("oversize", 1'b0, 1'b1, 1'b0);

        // Maximum count N=256
        do_reset();
        send(8'h01, 1'b1, 0);
        send(8'h00, 1'b1, 0);
        x = 8'h00;
        for (int wi = 0; wi < 256; wi++) begin
            for (int k = 0; k < 4; k++) begin
                b = 8'((wi * 4 + k) * 37 + 11);
                w = {w[23:0], b};
                x = x ^ b;
                if (k == 3) push_wr(8'(wi), w);
                send(b, 1'b1, 0);
            end
        end
        chk("max_pre_done", {31'd0, done}, 0);
        send(x, 1'b1, 0);
        status("max", 1'b1, 1'b0, 1'b0);
        chk("max_pending", exp_q.size(), 0);

        // rx_valid toggling with garbage in the gaps
        do_reset();
        nominal(8'h55, 1);
        status("gaps", 1'b1, 1'b0, 1'b0);
        chk("gaps_pending", exp_q.size(), 0);

        // Reset after two data bytes, then replay
        do_reset();
        send(8'h00, 1'b1, 0);
        send(8'h02, 1'b1, 0);
        send(8'h20, 1'b1, 0);
        send(8'h08, 1'b1, 0);
        do_reset();
        nominal(8'h55, 0);
        status("midreset", 1'b1, 1'b0, 1'b0);
        chk("midreset_pending", exp_q.size(), 0);

        // Reset after the first word was written: outputs must clear immediately
        do_reset();
        push_wr(8'd0, 32'h20080005);
        send(8'h00, 1'b1, 0);
        send(8'h02, 1'b1, 0);
        send(8'h20, 1'b1, 0);
        send(8'h08, 1'b1, 0);
        send(8'h00, 1'b1, 0);
        send(8'h05, 1'b1, 0);
        send(8'h01, 1'b1, 0);
        chk("midreset2_pending", exp_q.size(), 0);
        do_reset();
        nominal(8'h55, 0);
        status("midreset2", 1'b1, 1'b0, 1'b0);
        chk("midreset2_final_pending", exp_q.size(), 0);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
